mdr_mem_unit: RTL and testbench

Memory data/address register pair with a request/acknowledge memory handshake for the datapath. It captures addresses and data from the shared 32-bit bus output and runs single-word reads and writes against external memory. The MDR contents it presents become the bus multiplexer's MDR input, selected there by MDRout. A small FSM stalls the control sequencer through `busy` until memory acknowledges the access.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_wait_timer.sv | 31 +++
 rtl/mdr_mem_unit.sv | 99 +++++++++
 tb/tb_mdr_mem_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the MDR/MAR memory unit.
package mem_pkg;
  localparam int DATA_W      = 32;
  localparam int ADDR_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; expired_o flags the last allowed wait cycle.
// Latency: combinational expiry from the count register; backpressure: none, counts while inc_i.
module mem_wait_timer
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The increment at this edge would make the count reach TIMEOUT.
  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mdr_mem_unit.sv
// MAR/MDR register pair with req/ack single-word memory access; busy stalls the sequencer.
// Optional MEM_TIMEOUT_EN macro adds an abort-on-timeout wait counter and a sticky err flag.
module mdr_mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);
  mem_state_t        state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              waiting;
  logic              start;
  logic              tmo_hit;

  assign waiting = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign start   = (state_q == IDLE) && (read || write);

`ifdef MEM_TIMEOUT_EN
  logic tmr_expired;
  logic err_q;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (start),
    .inc_i    (waiting && !mem_ack),
    .expired_o(tmr_expired)
  );

  assign tmo_hit = waiting && tmr_expired && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Ack is checked ahead of timeout so a same-cycle ack completes normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mar_in) mar_q <= bus_data[ADDR_W-1:0];
          if (mdr_in) mdr_q <= bus_data;
          if (read)       state_q <= RD_WAIT;
          else if (write) state_q <= WR_WAIT;
        end
        RD_WAIT: begin
          if (mem_ack) begin
            mdr_q   <= mem_rdata;
            state_q <= DONE;
          end else if (tmo_hit) begin
            state_q <= DONE;
          end
        end
        WR_WAIT: begin
          if (mem_ack || tmo_hit) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdr_data  = mdr_q;
  assign mem_wdata = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_req   = waiting;
  assign mem_we    = (state_q == WR_WAIT);
  assign busy      = waiting;
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_mdr_mem_unit.sv
// Directed bench for mdr_mem_unit: reset, MAR/MDR loads, read/write handshakes, priority, reset mid-access, timeout.
module tb_mdr_mem_unit;
  import mem_pkg::*;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   bus_data;
  logic          mar_in, mdr_in, read, write;
  logic [31:0]   mdr_data;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_req, mem_we;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          busy, done, err;

  int total = 0;
  int passed = 0;

  mdr_mem_unit #(.ADDR_W(AW), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_data (bus_data),
    .mar_in   (mar_in),
    .mdr_in   (mdr_in),
    .read     (read),
    .write    (write),
    .mdr_data (mdr_data),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_data = '0; mar_in = 0; mdr_in = 0; read = 0; write = 0;
    mem_rdata = '0; mem_ack = 0;
    step(); step();
    total++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", mem_req); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_flags: busy=%0b done=%0b we=%0b want 0", busy, done, mem_we); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err: got %0b want 0", err); else passed++;
    total++; if (mdr_data !== 32'h0 || mem_addr !== 9'h0) $display("FAIL rst_regs: mdr=%h addr=%h want 0", mdr_data, mem_addr); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mar_load();
    bus_data = 32'h0000_01F4; mar_in = 1;
    step();
    mar_in = 0; bus_data = 32'h0;
    total++; if (mem_addr !== 9'h1F4) $display("FAIL mar_load: got %h want 1f4", mem_addr); else passed++;
    bus_data = 32'hFFFF_FE10; mar_in = 1;
    step();
    mar_in = 0; bus_data = 32'h0;
    total++; if (mem_addr !== 9'h010) $display("FAIL mar_trunc: got %h want 010", mem_addr); else passed++;
  endtask

  task automatic test_read();
    int nbusy;
    read = 1;
    step();
    read = 0;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL rd_req: req=%0b we=%0b want 1/0", mem_req, mem_we); else passed++;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 10) begin
      nbusy++;
      if (nbusy == 3) begin mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; end
      step();
      mem_ack = 0; mem_rdata = '0;
    end
    total++; if (nbusy != 3) $display("FAIL rd_busy_len: got %0d want 3", nbusy); else passed++;
    total++; if (done !== 1'b1 || mem_req !== 1'b0) $display("FAIL rd_done: done=%0b req=%0b want 1/0", done, mem_req); else passed++;
    total++; if (mdr_data !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", mdr_data); else passed++;
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rd_done_pulse: done=%0b busy=%0b want 0/0", done, busy); else passed++;
  endtask

  task automatic test_write();
    bus_data = 32'h1234_5678; mdr_in = 1; write = 1;
    step();
    mdr_in = 0; write = 0; bus_data = 32'hFFFF_FFFF;
    total++; if (mem_we !== 1'b1 || mem_req !== 1'b1) $display("FAIL wr_req: we=%0b req=%0b want 1/1", mem_we, mem_req); else passed++;
    total++; if (mem_wdata !== 32'h1234_5678 || mem_addr !== 9'h010) $display("FAIL wr_out: wdata=%h addr=%h want 12345678/010", mem_wdata, mem_addr); else passed++;
    mem_ack = 1;
    step();
    mem_ack = 0;
    total++; if (done !== 1'b1 || mem_we !== 1'b0) $display("FAIL wr_done: done=%0b we=%0b want 1/0", done, mem_we); else passed++;
    total++; if (mdr_data !== 32'h1234_5678) $display("FAIL wr_mdr: got %h want 12345678", mdr_data); else passed++;
    step();
  endtask

  task automatic test_priority();
    read = 1; write = 1;
    step();
    read = 0; write = 0;
    total++; if (mem_we !== 1'b0 || mem_req !== 1'b1) $display("FAIL prio_rd: we=%0b req=%0b want 0/1", mem_we, mem_req); else passed++;
    bus_data = 32'hAAAA_5555; mdr_in = 1; mar_in = 1;
    step();
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0; mem_rdata = '0; mdr_in = 0; mar_in = 0;
    total++; if (mdr_data !== 32'h0BAD_F00D || mem_addr !== 9'h010) $display("FAIL prio_ignore: mdr=%h addr=%h want 0badf00d/010", mdr_data, mem_addr); else passed++;
    write = 1; mdr_in = 1;
    step();
    write = 0; mdr_in = 0;
    total++; if (busy !== 1'b0 || mdr_data !== 32'h0BAD_F00D) $display("FAIL done_cmd_ignored: busy=%0b mdr=%h want 0/0badf00d", busy, mdr_data); else passed++;
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    step();
    mem_ack = 0; mem_rdata = '0;
    total++; if (mdr_data !== 32'h0BAD_F00D || done !== 1'b0) $display("FAIL idle_ack: mdr=%h done=%0b want 0badf00d/0", mdr_data, done); else passed++;
  endtask

  task automatic test_back_to_back();
    read = 1;
    step();
    mem_ack = 1; mem_rdata = 32'h0000_0001;
    step();
    mem_ack = 0;
    total++; if (done !== 1'b1) $display("FAIL b2b_done: got %0b want 1", done); else passed++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL b2b_gap: busy=%0b want 0", busy); else passed++;
    step();
    read = 0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%0b want 1", busy); else passed++;
    mem_ack = 1; mem_rdata = 32'h0000_0002;
    step();
    mem_ack = 0;
    total++; if (mdr_data !== 32'h0000_0002) $display("FAIL b2b_data: got %h want 00000002", mdr_data); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    read = 1;
    step();
    read = 0;
    step();
    rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_req: req=%0b busy=%0b want 0/0", mem_req, busy); else passed++;
    total++; if (mdr_data !== 32'h0) $display("FAIL rstmid_mdr: got %h want 0", mdr_data); else passed++;
    step();
    rst_n = 1'b1;
    step();
    bus_data = 32'h0000_0055; mar_in = 1; read = 1;
    step();
    mar_in = 0; read = 0; bus_data = '0;
    total++; if (mem_addr !== 9'h055 || mem_req !== 1'b1) $display("FAIL rstmid_addr: addr=%h req=%0b want 055/1", mem_addr, mem_req); else passed++;
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 0; mem_rdata = '0;
    total++; if (mdr_data !== 32'hCAFE_F00D || done !== 1'b1) $display("FAIL rstmid_read: mdr=%h done=%0b want cafef00d/1", mdr_data, done); else passed++;
    step();
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    int nbusy;
    read = 1;
    step();
    read = 0;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      step();
    end
    total++; if (nbusy != 15) $display("FAIL tmo_len: got %0d want 15", nbusy); else passed++;
    total++; if (done !== 1'b1 || err !== 1'b1) $display("FAIL tmo_done: done=%0b err=%0b want 1/1", done, err); else passed++;
    total++; if (mdr_data !== 32'hCAFE_F00D) $display("FAIL tmo_mdr: got %h want cafef00d", mdr_data); else passed++;
    step();
    read = 1;
    step();
    read = 0;
    mem_ack = 1; mem_rdata = 32'h5A5A_A5A5;
    step();
    mem_ack = 0; mem_rdata = '0;
    total++; if (mdr_data !== 32'h5A5A_A5A5 || err !== 1'b1) $display("FAIL tmo_after: mdr=%h err=%0b want 5a5aa5a5/1", mdr_data, err); else passed++;
    step();
`else
    total++; if (err !== 1'b0) $display("FAIL err_tied: got %0b want 0", err); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_mar_load();
    test_read();
    test_write();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
